drum_voice_player: RTL and testbench

Sound-generation back end for the drum machine sequencer. It consumes the five per-step voice strobes produced by the pattern state machine (Aout..Eout) and turns each into a fixed-length square-wave burst, one distinct pitch per voice. It produces a 3-bit voice mix and a 1-bit speaker drive for the board's audio pin, and reports per-voice activity for LEDs and debug.

---
 rtl/drum_voice_player.sv | 117 +++++++++++
 tb/tb_drum_voice_player.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/drum_voice_player.sv
// Five-voice square-wave burst generator for the drum sequencer.
// Each rising trigger edge starts (or restarts) a fixed-length tone at a per-voice pitch.
module drum_voice_player #(
  parameter int DUR       = 8,
  parameter int BASE_HALF = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       playing,
  input  logic [4:0] Trig,
  output logic [4:0] Active,
  output logic [2:0] Mix,
  output logic       Speaker
);

  typedef enum logic {S_IDLE, S_SOUND} state_t;

  localparam int unsigned NV     = 5;
  localparam logic [15:0] DUR_M1 = 16'(DUR - 1);

  state_t      r_state [NV];
  logic [15:0] r_dur   [NV];
  logic [15:0] r_div   [NV];
  logic [4:0]  r_sq;
  logic [4:0]  r_trig_q;
  logic [2:0]  r_mix;
  logic        r_spk;

  logic [4:0]  w_edge;
  logic [15:0] w_half_m1 [NV];
  logic [2:0]  w_pop;

  always_comb begin
    w_edge = Trig & ~r_trig_q;
  end

  // Voice i runs at half-period BASE_HALF*(i+1); the divider reloads with that minus one.
  always_comb begin
    for (int unsigned i = 0; i < NV; i++) begin
      w_half_m1[i] = 16'(BASE_HALF * int'(i + 1) - 1);
    end
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < NV; i++) begin
      w_pop = w_pop + 3'(r_sq[i]);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NV; i++) begin
      Active[i] = (r_state[i] == S_SOUND);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < NV; i++) begin
        r_state[i] <= S_IDLE;
        r_dur[i]   <= '0;
        r_div[i]   <= '0;
      end
      r_sq     <= '0;
      r_trig_q <= '0;
      r_mix    <= '0;
      r_spk    <= 1'b0;
    end else begin
      r_trig_q <= Trig;
      for (int unsigned i = 0; i < NV; i++) begin
        case (r_state[i])
          S_IDLE: begin
            r_sq[i] <= 1'b0;
            if (w_edge[i] && playing) begin
              r_state[i] <= S_SOUND;
              r_dur[i]   <= DUR_M1;
              r_div[i]   <= w_half_m1[i];
              r_sq[i]    <= 1'b1;
            end
          end
          S_SOUND: begin
            if (!playing) begin
              r_state[i] <= S_IDLE;
              r_sq[i]    <= 1'b0;
            end else if (w_edge[i]) begin
              // Retrigger restarts both the duration and the tone phase.
              r_dur[i] <= DUR_M1;
              r_div[i] <= w_half_m1[i];
              r_sq[i]  <= 1'b1;
            end else if (r_dur[i] == '0) begin
              r_state[i] <= S_IDLE;
              r_sq[i]    <= 1'b0;
            end else begin
              r_dur[i] <= r_dur[i] - 16'd1;
              if (r_div[i] == '0) begin
                r_div[i] <= w_half_m1[i];
                r_sq[i]  <= ~r_sq[i];
              end else begin
                r_div[i] <= r_div[i] - 16'd1;
              end
            end
          end
          default: begin
            r_state[i] <= S_IDLE;
            r_sq[i]    <= 1'b0;
          end
        endcase
      end
      r_mix <= w_pop;
      r_spk <= |r_sq;
    end
  end

  assign Mix     = r_mix;
  assign Speaker = r_spk;

endmodule

// File: tb/tb_drum_voice_player.sv
// Bench for drum_voice_player: two instances (DUR=8/BASE_HALF=2 and DUR=1/BASE_HALF=3)
// checked against a timestamp-based model of each voice's burst.
module tb_drum_voice_player;

  localparam int DUR0 = 8;
  localparam int BH0  = 2;
  localparam int DUR1 = 1;
  localparam int BH1  = 3;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       playing;
  logic [4:0] Trig;
  logic [4:0] act0, act1;
  logic [2:0] mix0, mix1;
  logic       spk0, spk1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [4:0] m_prev;
  bit         m_act   [2][5];
  int         m_start [2][5];
  logic [2:0] m_mix   [2];
  logic       m_spk   [2];

  drum_voice_player #(.DUR(DUR0), .BASE_HALF(BH0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .playing(playing), .Trig(Trig),
    .Active(act0), .Mix(mix0), .Speaker(spk0)
  );

  drum_voice_player #(.DUR(DUR1), .BASE_HALF(BH1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .playing(playing), .Trig(Trig),
    .Active(act1), .Mix(mix1), .Speaker(spk1)
  );

  always #5 Clk = ~Clk;

  function automatic int dur_of(int d);
    return (d == 0) ? DUR0 : DUR1;
  endfunction

  function automatic int half_of(int d, int v);
    return ((d == 0) ? BH0 : BH1) * (v + 1);
  endfunction

  // Square level: high during even-numbered half-periods since the burst start.
  function automatic bit m_sq(int d, int v);
    if (!m_act[d][v]) return 1'b0;
    return (((cyc - m_start[d][v]) / half_of(d, v)) % 2) == 0;
  endfunction

  function automatic logic [4:0] m_active(int d);
    logic [4:0] a;
    for (int v = 0; v < 5; v++) a[v] = m_act[d][v];
    return a;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < 5; v++) m_act[d][v] = 1'b0;
      m_mix[d] = '0;
      m_spk[d] = 1'b0;
    end
    m_prev = '0;
  endtask

  task automatic model_edge();
    int pop;
    for (int d = 0; d < 2; d++) begin
      pop = 0;
      for (int v = 0; v < 5; v++) pop += int'(m_sq(d, v));
      m_mix[d] = 3'(pop);
      m_spk[d] = (pop != 0);
    end
    cyc++;
    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < 5; v++) begin
        if (!playing) m_act[d][v] = 1'b0;
        else if (Trig[v] && !m_prev[v]) begin
          m_act[d][v]   = 1'b1;
          m_start[d][v] = cyc;
        end else if (m_act[d][v] && (cyc - m_start[d][v]) >= dur_of(d)) m_act[d][v] = 1'b0;
      end
    end
    m_prev = Trig;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("active0", 8'(act0), 8'(m_active(0)));
    chk("mix0",    8'(mix0), 8'(m_mix[0]));
    chk("spk0",    8'(spk0), 8'(m_spk[0]));
    chk("active1", 8'(act1), 8'(m_active(1)));
    chk("mix1",    8'(mix1), 8'(m_mix[1]));
    chk("spk1",    8'(spk1), 8'(m_spk[1]));
  endtask

  task automatic step(input logic [4:0] t, input logic p);
    Trig    = t;
    playing = p;
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_act0"}, 8'(act0), 8'd0);
    chk({tag, "_mix0"}, 8'(mix0), 8'd0);
    chk({tag, "_spk0"}, 8'(spk0), 8'd0);
    chk({tag, "_act1"}, 8'(act1), 8'd0);
  endtask

  initial begin
    int cnt0, cnt1;
    Reset   = 1'b0;
    Trig    = '0;
    playing = 1'b0;
    m_reset();
    #1;
    check_zero("reset");
    #22;
    Reset = 1'b1;
    #7;

    // single voice 0 burst
    step(5'b00001, 1'b1);
    step(5'b00001, 1'b1);
    repeat (10) step(5'b00000, 1'b1);

    // asynchronous reset in the middle of a burst
    step(5'b00001, 1'b1);
    step(5'b00000, 1'b1);
    step(5'b00000, 1'b1);
    #2;
    Reset = 1'b0;
    m_reset();
    #1;
    check_zero("async_rst");
    #2;
    Reset = 1'b1;
    repeat (4) step(5'b00000, 1'b1);
    check_zero("post_rst");

    // all five voices on one edge
    step(5'b11111, 1'b1);
    step(5'b00000, 1'b1);
    chk("all5_mix", 8'(mix0), 8'd5);
    repeat (10) step(5'b00000, 1'b1);

    // retrigger on voice 2
    step(5'b00100, 1'b1);
    step(5'b00100, 1'b1);
    step(5'b00000, 1'b1);
    step(5'b00000, 1'b1);
    step(5'b00100, 1'b1);
    repeat (12) step(5'b00000, 1'b1);

    // stop while voices 1 and 3 sound; trigger ignored while stopped
    step(5'b01010, 1'b1);
    step(5'b00000, 1'b1);
    step(5'b00000, 1'b1);
    step(5'b00000, 1'b0);
    chk("stop_act", 8'(act0), 8'd0);
    step(5'b00000, 1'b0);
    chk("stop_spk", 8'(spk0), 8'd0);
    step(5'b00010, 1'b0);
    repeat (3) step(5'b00010, 1'b0);
    step(5'b00000, 1'b1);

    // held trigger on voice 4 gives exactly one burst
    cnt0 = 0;
    cnt1 = 0;
    repeat (40) begin
      step(5'b10000, 1'b1);
      cnt0 += int'(act0[4]);
      cnt1 += int'(act1[4]);
    end
    chk("held_cnt0", 8'(cnt0), 8'(DUR0));
    chk("held_cnt1", 8'(cnt1), 8'(DUR1));
    step(5'b00000, 1'b1);

    // trigger held high across reset release is accepted on the first edge
    Trig = 5'b10000;
    #2;
    Reset = 1'b0;
    m_reset();
    #1;
    check_zero("held_rst");
    #3;
    Reset = 1'b1;
    step(5'b10000, 1'b1);
    chk("held_rel", 8'(act0[4]), 8'd1);
    repeat (10) step(5'b00000, 1'b1);

    // randomized traffic
    repeat (400) begin
      logic [4:0] t;
      t = 5'($urandom) & 5'($urandom);
      step(t, ($urandom_range(0, 15) != 0));
    end
    repeat (12) step(5'b00000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
